arm7tdmi_ex_wb: RTL
===================

ARM7TDMI_EX_WB -- requirements
Module: arm7tdmi_ex_wb

Interface
REQ-001 SHALL have parameter: RD_W, 4, register-index width.
REQ-002 SHALL have port: clk  in  1  core clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ex_valid  in  1  execute stage presents an ALU result.
REQ-005 SHALL have port: ex_ready  out  1  this stage accepts the presented result.
REQ-006 SHALL have ports: alu_op  in  alu_op_t; set_flags  in  1; rd  in  RD_W  (the ALU's op, S-bit, destination).
REQ-007 SHALL have ports: result  in  32; negative, zero, carry_out, overflow  in  1 each  (ALU outputs).
REQ-008 SHALL have port: flush  in  1  discard the held and the presented result (branch/exception).
REQ-009 SHALL have ports: wb_valid  out  1; wb_ready  in  1  (writeback handshake).
REQ-010 SHALL have ports: wb_we  out  1; wb_rd  out  RD_W; wb_data  out  32  (register-file write).
REQ-011 SHALL have port: flags_nzcv  out  4  architectural N,Z,C,V in bits [3:0]; bit[1] drives ALU carry_in.
REQ-012 SHALL have port: retire_cnt  out  32  count of completed writeback handshakes.

Function
REQ-013 SHALL hold one entry; ex_ready = !wb_valid || wb_ready (combinational, no dependence on ex_valid).
REQ-014 SHALL accept when ex_valid && ex_ready && !flush; entry visible on wb_* the next cycle (latency 1).
REQ-015 SHALL clear wb_valid after a wb_valid && wb_ready cycle with no accept; accept and drain in the same cycle SHALL replace the entry (full throughput).
REQ-016 SHALL keep wb_* stable while wb_valid && !wb_ready.
REQ-017 SHALL set wb_we = 0 for ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN; 1 for all other ops.
REQ-018 SHALL update flags_nzcv on the accept edge only when set_flags = 1, so the next ALU op sees new carry_in one cycle after accept.
REQ-019 Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN) SHALL load N,Z,C,V from inputs.
REQ-020 Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) SHALL load N,Z,C and retain V.
REQ-021 flush SHALL clear wb_valid on the next edge, block any same-cycle accept and its flag update, and take priority over wb_ready.
REQ-022 retire_cnt SHALL increment by 1 on each wb_valid && wb_ready cycle not coinciding with flush, wrapping 0xFFFFFFFF -> 0.
REQ-023 Unknown alu_op values SHALL be accepted with wb_we = 0 and no flag update.

Reset
REQ-024 SHALL, on rst_n low, immediately force wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, flags_nzcv=4'b0000, retire_cnt=0.
REQ-025 Reset mid-stall SHALL drop the held entry; first accept after release behaves as from empty.

Configuration
REQ-026 With ARM7TDMI_EXWB_FWD_EN defined, SHALL add outputs fwd_valid (1), fwd_rd (RD_W), fwd_data (32) equal to wb_valid && wb_we, wb_rd, wb_data, for operand bypass.
REQ-027 Without ARM7TDMI_EXWB_FWD_EN, those ports SHALL not exist; all other behaviour identical.

Verification
REQ-028 ADD result 0x0000_0000, C=1,V=0,Z=1, set_flags=1, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, flags_nzcv=4'b0110.
REQ-029 flags=4'b0001, MOV result 0x8000_0000 C=0 set_flags=1 -> flags_nzcv=4'b1001 (V retained).
REQ-030 CMP with set_flags=1 -> wb_we=0, flags updated, retire_cnt still increments on handshake.
REQ-031 wb_ready=0 for 3 cycles with entry held, ex_valid=1 -> ex_ready=0, wb_data stable, flags unchanged; wb_ready=1 -> back-to-back accept and drain.
REQ-032 flush concurrent with ex_valid=1, set_flags=1 -> wb_valid=0 next cycle, flags_nzcv unchanged, retire_cnt unchanged.
REQ-033 retire_cnt preloaded to 0xFFFFFFFF via handshakes, one more handshake -> 0; rst_n pulse mid-stall -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/arm7tdmi_ex_wb_if.sv
// ALU-op encoding and the execute->writeback handshake bundle for arm7tdmi_ex_wb.
package arm7tdmi_ex_wb_pkg;
  typedef enum logic [4:0] {
    ALU_AND = 5'd0, ALU_EOR, ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
    ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
  } alu_op_t;
endpackage

interface arm7tdmi_ex_wb_if #(
  parameter int unsigned RD_W = 4
);
  import arm7tdmi_ex_wb_pkg::*;

  logic            ex_valid;
  logic            ex_ready;
  alu_op_t         alu_op;
  logic            set_flags;
  logic [RD_W-1:0] rd;
  logic [31:0]     result;
  logic            negative;
  logic            zero;
  logic            carry_out;
  logic            overflow;
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_we;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;

  modport master (
    output ex_valid, alu_op, set_flags, rd, result, negative, zero, carry_out, overflow,
    output wb_ready,
    input  ex_ready, wb_valid, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  ex_valid, alu_op, set_flags, rd, result, negative, zero, carry_out, overflow,
    input  wb_ready,
    output ex_ready, wb_valid, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/arm7tdmi_ex_wb.sv
// ARM7TDMI execute->writeback register: one-entry skid, NZCV flag update, retire counter.
// Define ARM7TDMI_EXWB_FWD_EN to add the fwd_valid/fwd_rd/fwd_data operand-bypass outputs.
module arm7tdmi_ex_wb
  import arm7tdmi_ex_wb_pkg::*;
#(
  parameter int unsigned RD_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  arm7tdmi_ex_wb_if.slave     bus,
  input  logic                flush,
  output logic [3:0]          flags_nzcv,
  output logic [31:0]         retire_cnt
`ifdef ARM7TDMI_EXWB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [RD_W-1:0]     fwd_rd,
  output logic [31:0]         fwd_data
`endif
);

  logic            wb_valid_q;
  logic            wb_we_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [31:0]     wb_data_q;
  logic [3:0]      flags_q;
  logic [31:0]     retire_q;

  logic ex_ready;
  logic accept;
  logic drain;
  logic op_known;
  logic op_arith;
  logic op_cmp;
  logic [3:0] flags_d;

  assign ex_ready = !wb_valid_q || bus.wb_ready;
  assign accept   = bus.ex_valid && ex_ready && !flush;
  assign drain    = wb_valid_q && bus.wb_ready;

  always_comb begin
    op_known = 1'b1;
    op_arith = 1'b0;
    op_cmp   = 1'b0;
    case (bus.alu_op)
      ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC: op_arith = 1'b1;
      ALU_CMP, ALU_CMN: begin
        op_arith = 1'b1;
        op_cmp   = 1'b1;
      end
      ALU_TST, ALU_TEQ: op_cmp = 1'b1;
      ALU_AND, ALU_EOR, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  // Logical ops leave V alone; arithmetic ops take all four flags from the ALU.
  always_comb begin
    flags_d = flags_q;
    if (op_arith) begin
      flags_d = {bus.negative, bus.zero, bus.carry_out, bus.overflow};
    end else begin
      flags_d = {bus.negative, bus.zero, bus.carry_out, flags_q[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flags_q    <= 4'b0000;
      retire_q   <= '0;
    end else begin
      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (accept) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= op_known && !op_cmp;
        wb_rd_q    <= bus.rd;
        wb_data_q  <= bus.result;
        if (bus.set_flags && op_known) begin
          flags_q <= flags_d;
        end
      end else if (drain) begin
        wb_valid_q <= 1'b0;
      end
      if (drain && !flush) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign bus.ex_ready = ex_ready;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign flags_nzcv   = flags_q;
  assign retire_cnt   = retire_q;

`ifdef ARM7TDMI_EXWB_FWD_EN
  assign fwd_valid = wb_valid_q && wb_we_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule
